pipelined_multiplier_rs: RTL and testbench

//  Parametrised N x N pipelined multiplier. Retires K multiplier bits per stage (radix 2^K).

---
 rtl/pipelined_multiplier_rs_pkg.sv | 18 +
 rtl/pipelined_multiplier_rs_if.sv | 32 +++
 rtl/pipelined_multiplier_rs_stage.sv | 71 +++++++
 rtl/pipelined_multiplier_rs.sv | 116 +++++++++++
 tb/tb_pipelined_multiplier_rs.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_multiplier_rs_pkg.sv
// Shared defaults and elaboration helpers for the radix-2^K pipelined multiplier.
package pipelined_multiplier_rs_pkg;

    localparam int DEF_N     = 8;
    localparam int DEF_K     = 2;
    localparam int DEF_TAG_W = 4;

    // Number of arithmetic stages: one per K-bit multiplier digit.
    function automatic int stage_count(input int n, input int k);
        return n / k;
    endfunction

    // K must split the multiplier into whole digits.
    function automatic bit k_is_legal(input int n, input int k);
        return (k >= 1) && (k <= n) && ((n % k) == 0);
    endfunction

endpackage

// File: rtl/pipelined_multiplier_rs_if.sv
// Valid/ready operand and result channels of the pipelined multiplier.
interface pipelined_multiplier_rs_if
    import pipelined_multiplier_rs_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int TAG_W = DEF_TAG_W
) ();

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             in_signed;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   product;
    logic [TAG_W-1:0] out_tag;

    // Producer of operands and consumer of results.
    modport master (
        output in_valid, a, b, in_signed, in_tag, out_ready,
        input  in_ready, out_valid, product, out_tag
    );

    // The multiplier itself.
    modport slave (
        input  in_valid, a, b, in_signed, in_tag, out_ready,
        output in_ready, out_valid, product, out_tag
    );

endinterface

// File: rtl/pipelined_multiplier_rs_stage.sv
// One radix-2^K step: adds the partial product of the current low digit of b,
// then shifts the remaining digits down for the next stage.
module pipelined_multiplier_rs_stage
    import pipelined_multiplier_rs_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int K         = DEF_K,
    parameter int TAG_W     = DEF_TAG_W,
    parameter int STAGE_IDX = 0,
    parameter bit IS_LAST   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up_vld,
    input  logic signed [2*N-1:0] up_acc,
    input  logic signed [2*N-1:0] up_a_ext,
    input  logic        [N-1:0]   up_b,
    input  logic                  up_sgn,
    input  logic [TAG_W-1:0]      up_tag,
    output logic                  dn_vld,
    output logic signed [2*N-1:0] dn_acc,
    output logic signed [2*N-1:0] dn_a_ext,
    output logic        [N-1:0]   dn_b,
    output logic                  dn_sgn,
    output logic [TAG_W-1:0]      dn_tag
);

    localparam int ACC_W = 2 * N;
    localparam int SHIFT = K * STAGE_IDX;

    // The top digit of a signed multiplier carries weight -2^(K-1) on its MSB,
    // so it is sign-extended; every other digit is a plain unsigned value.
    function automatic logic signed [ACC_W-1:0] partial_product(
        input logic signed [ACC_W-1:0] a_s,
        input logic        [K-1:0]     digit,
        input logic                    sgn
    );
        logic signed [K:0]       d_s;
        logic signed [ACC_W-1:0] d_w;
        if (IS_LAST && sgn) d_s = {digit[K-1], digit};
        else                d_s = {1'b0, digit};
        d_w = ACC_W'(d_s);
        return a_s * d_w;
    endfunction

    logic signed [ACC_W-1:0] acc_next;

    // Accumulate this digit's weighted partial product, wrapping mod 2^(2N).
    always_comb begin
        acc_next = up_acc + (partial_product(up_a_ext, up_b[K-1:0], up_sgn) <<< SHIFT);
    end

    // Stage valid: cleared by reset, frozen while the pipeline is stalled.
    always_ff @(posedge clk) begin
        if (rst)     dn_vld <= 1'b0;
        else if (en) dn_vld <= up_vld;
    end

    // Stage data: advances with the pipeline; contents of bubbles are don't-care.
    always_ff @(posedge clk) begin
        if (en) begin
            dn_acc   <= acc_next;
            dn_a_ext <= up_a_ext;
            dn_b     <= up_b >> K;
            dn_sgn   <= up_sgn;
            dn_tag   <= up_tag;
        end
    end

endmodule

// File: rtl/pipelined_multiplier_rs.sv
// N x N pipelined multiplier, K multiplier bits per stage, with per-operation
// signed/unsigned mode, sideband tag and valid/ready backpressure.
module pipelined_multiplier_rs
    import pipelined_multiplier_rs_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int K     = DEF_K,
    parameter int TAG_W = DEF_TAG_W
) (
    input logic                      clk,
    input logic                      rst,
    pipelined_multiplier_rs_if.slave bus
);

    localparam int S     = stage_count(N, K);
    localparam int ACC_W = 2 * N;

    if (!k_is_legal(N, K)) begin : g_bad_k
        $error("pipelined_multiplier_rs: K must divide N and lie in 1..N");
    end

    // Multiplicand widened to the accumulator width according to the mode.
    function automatic logic signed [ACC_W-1:0] extend_a(input logic [N-1:0] a, input logic sgn);
        if (sgn) return ACC_W'($signed(a));
        return ACC_W'(a);
    endfunction

    logic                    stall;
    logic                    en;
    logic                    vld_p0;
    logic signed [ACC_W-1:0] a_ext_p0;
    logic        [N-1:0]     b_p0;
    logic                    sgn_p0;
    logic [TAG_W-1:0]        tag_p0;
    logic                    out_valid_p;
    logic signed [ACC_W-1:0] product_p;
    logic [TAG_W-1:0]        out_tag_p;

    // Stage chain: index 0 is the input capture, index i+1 the output of stage i.
    logic                    vld_c   [S+1];
    logic signed [ACC_W-1:0] acc_c   [S+1];
    logic signed [ACC_W-1:0] a_ext_c [S+1];
    logic        [N-1:0]     b_c     [S+1];
    logic                    sgn_c   [S+1];
    logic [TAG_W-1:0]        tag_c   [S+1];

    // A held result blocks the whole pipeline; bubbles are not squeezed out.
    assign stall        = out_valid_p && !bus.out_ready;
    assign en           = !stall;
    assign bus.in_ready = !rst && !stall;

    // Input capture valid: an accepted operation enters, otherwise a bubble.
    always_ff @(posedge clk) begin
        if (rst)     vld_p0 <= 1'b0;
        else if (en) vld_p0 <= bus.in_valid;
    end

    // Input capture data: operands, mode and tag travel together from here on.
    always_ff @(posedge clk) begin
        if (en) begin
            a_ext_p0 <= extend_a(bus.a, bus.in_signed);
            b_p0     <= bus.b;
            sgn_p0   <= bus.in_signed;
            tag_p0   <= bus.in_tag;
        end
    end

    assign vld_c[0]   = vld_p0;
    assign acc_c[0]   = '0;
    assign a_ext_c[0] = a_ext_p0;
    assign b_c[0]     = b_p0;
    assign sgn_c[0]   = sgn_p0;
    assign tag_c[0]   = tag_p0;

    for (genvar i = 0; i < S; i++) begin : g_stage
        pipelined_multiplier_rs_stage #(
            .N(N), .K(K), .TAG_W(TAG_W), .STAGE_IDX(i), .IS_LAST(i == S - 1)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .up_vld  (vld_c[i]),
            .up_acc  (acc_c[i]),
            .up_a_ext(a_ext_c[i]),
            .up_b    (b_c[i]),
            .up_sgn  (sgn_c[i]),
            .up_tag  (tag_c[i]),
            .dn_vld  (vld_c[i+1]),
            .dn_acc  (acc_c[i+1]),
            .dn_a_ext(a_ext_c[i+1]),
            .dn_b    (b_c[i+1]),
            .dn_sgn  (sgn_c[i+1]),
            .dn_tag  (tag_c[i+1])
        );
    end

    // Output register: keeps the last product across bubbles, drops only out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_p <= 1'b0;
            product_p   <= '0;
            out_tag_p   <= '0;
        end else if (en) begin
            out_valid_p <= vld_c[S];
            if (vld_c[S]) begin
                product_p <= acc_c[S];
                out_tag_p <= tag_c[S];
            end
        end
    end

    assign bus.out_valid = out_valid_p;
    assign bus.product   = product_p;
    assign bus.out_tag   = out_tag_p;

endmodule

// File: tb/tb_pipelined_multiplier_rs.sv
// Bench for pipelined_multiplier_rs: directed and random operations on the
// default N=8,K=2 build, plus random mixed-mode runs on three other shapes.
module tb_pipelined_multiplier_rs;

    localparam int N          = 8;
    localparam int K          = 2;
    localparam int TAG_W      = 4;
    localparam int LAT_EDGES  = 5;
    localparam int ALT_OPS    = 1000;
    localparam int ALT_BUDGET = 6000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit alt_go = 1'b0;
    bit alt_done [3];

    pipelined_multiplier_rs_if #(.N(N), .TAG_W(TAG_W)) mbus ();
    pipelined_multiplier_rs #(.N(N), .K(K), .TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bus(mbus));

    // Reference: the mathematical product of the two operands read in the
    // requested mode, reduced mod 2^(2*nbits).
    function automatic logic [31:0] ref_mul(input int nbits, input logic [31:0] a,
                                            input logic [31:0] b, input bit sgn);
        longint sa, sb, p;
        sa = longint'(a);
        sb = longint'(b);
        if (sgn && a[nbits-1]) sa = sa - (longint'(1) << nbits);
        if (sgn && b[nbits-1]) sb = sb - (longint'(1) << nbits);
        p = sa * sb;
        return 32'(p & ((longint'(1) << (2 * nbits)) - 1));
    endfunction

    logic [7:0]       op_a [64];
    logic [7:0]       op_b [64];
    logic             op_s [64];
    logic [TAG_W-1:0] op_t [64];
    logic [15:0]      res_p [64];
    logic [TAG_W-1:0] res_t [64];
    int               res_c [64];
    int               acc_c [64];
    int               n_res;
    logic             sv_rdy [8];
    logic [15:0]      sv_p [8];
    logic [TAG_W-1:0] sv_t [8];
    int               n_sv;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Streams op_*[0..n-1] back to back and records every consumed result.
    // With stall_len > 0, out_ready is held low for that many cycles as soon
    // as the first result is presented.
    task automatic run_ops(input int n, input int stall_len, input int budget);
        int issued;
        int stall_left;
        issued = 0;
        stall_left = stall_len;
        n_res = 0;
        n_sv = 0;
        for (int k = 0; k < budget && n_res < n; k++) begin
            step();
            mbus.out_ready = !(stall_left > 0 && mbus.out_valid);
            if (!mbus.out_ready) stall_left--;
            mbus.in_valid = (issued < n);
            if (issued < n) begin
                mbus.a         = op_a[issued];
                mbus.b         = op_b[issued];
                mbus.in_signed = op_s[issued];
                mbus.in_tag    = op_t[issued];
            end
            #1;
            if (!mbus.out_ready) begin
                sv_rdy[n_sv] = mbus.in_ready;
                sv_p[n_sv]   = mbus.product;
                sv_t[n_sv]   = mbus.out_tag;
                n_sv++;
            end
            if (mbus.out_valid && mbus.out_ready) begin
                res_p[n_res] = mbus.product;
                res_t[n_res] = mbus.out_tag;
                res_c[n_res] = cyc;
                n_res++;
            end
            if (mbus.in_valid && mbus.in_ready) begin
                acc_c[issued] = cyc;
                issued++;
            end
        end
        mbus.in_valid = 1'b0;
        checks++;
        if (n_res !== n) begin
            errors++;
            $display("FAIL run_ops_count got %0d results want %0d", n_res, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mbus.in_valid = 1'b0;
        mbus.out_ready = 1'b0;
        step();
        step();
        checks++;
        if (mbus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", mbus.out_valid); end
        checks++;
        if (mbus.product !== 16'h0000) begin errors++; $display("FAIL reset_product got %h want 0000", mbus.product); end
        checks++;
        if (mbus.out_tag !== 4'h0) begin errors++; $display("FAIL reset_out_tag got %h want 0", mbus.out_tag); end
        checks++;
        if (mbus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", mbus.in_ready); end
        rst = 1'b0;
        mbus.out_ready = 1'b1;
        #1;
        checks++;
        if (mbus.in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %b want 1", mbus.in_ready); end
    endtask

    task automatic test_latency();
        op_a[0] = 8'hFF; op_b[0] = 8'hFF; op_s[0] = 1'b0; op_t[0] = 4'h3;
        run_ops(1, 0, 30);
        checks++;
        if (res_p[0] !== 16'hFE01) begin errors++; $display("FAIL lat_product got %h want FE01", res_p[0]); end
        checks++;
        if (res_t[0] !== 4'h3) begin errors++; $display("FAIL lat_tag got %h want 3", res_t[0]); end
        // The accepting edge ends the cycle in which the handshake was sampled.
        checks++;
        if (res_c[0] - acc_c[0] - 1 !== LAT_EDGES) begin
            errors++;
            $display("FAIL lat_edges got %0d want %0d", res_c[0] - acc_c[0] - 1, LAT_EDGES);
        end
    endtask

    task automatic test_signed_modes();
        logic [7:0]  ta [7];
        logic [7:0]  tb [7];
        logic        ts [7];
        logic [15:0] tw [7];
        ta = '{8'h80, 8'hFF, 8'h7F, 8'h80, 8'hFF, 8'hFF, 8'h00};
        tb = '{8'h80, 8'h01, 8'h80, 8'h80, 8'hFF, 8'hFF, 8'hA5};
        ts = '{1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1};
        tw = '{16'h4000, 16'hFFFF, 16'hC080, 16'h4000, 16'hFE01, 16'h0001, 16'h0000};
        for (int i = 0; i < 7; i++) begin
            op_a[i] = ta[i]; op_b[i] = tb[i]; op_s[i] = ts[i]; op_t[i] = 4'(i + 1);
        end
        run_ops(7, 0, 40);
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (res_p[i] !== tw[i] || res_t[i] !== 4'(i + 1)) begin
                errors++;
                $display("FAIL mode_op%0d got %h tag %h want %h tag %h", i, res_p[i], res_t[i], tw[i], 4'(i + 1));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] want;
        for (int i = 0; i < 32; i++) begin
            op_a[i] = 8'($urandom); op_b[i] = 8'($urandom);
            op_s[i] = 1'($urandom); op_t[i] = 4'(i % 16);
        end
        run_ops(32, 0, 100);
        for (int i = 0; i < 32; i++) begin
            want = 16'(ref_mul(N, 32'(op_a[i]), 32'(op_b[i]), op_s[i]));
            checks++;
            if (res_p[i] !== want || res_t[i] !== op_t[i]) begin
                errors++;
                $display("FAIL b2b_op%0d got %h tag %h want %h tag %h", i, res_p[i], res_t[i], want, op_t[i]);
            end
            checks++;
            if (res_c[i] !== res_c[0] + i) begin
                errors++;
                $display("FAIL b2b_spacing_op%0d got cycle %0d want %0d", i, res_c[i], res_c[0] + i);
            end
        end
    endtask

    task automatic test_stall();
        logic [15:0] want;
        for (int i = 0; i < 10; i++) begin
            op_a[i] = 8'($urandom); op_b[i] = 8'($urandom);
            op_s[i] = 1'($urandom); op_t[i] = 4'(i + 2);
        end
        run_ops(10, 3, 60);
        checks++;
        if (n_sv !== 3) begin errors++; $display("FAIL stall_cycles got %0d want 3", n_sv); end
        want = 16'(ref_mul(N, 32'(op_a[0]), 32'(op_b[0]), op_s[0]));
        for (int j = 0; j < n_sv && j < 3; j++) begin
            checks++;
            if (sv_rdy[j] !== 1'b0) begin errors++; $display("FAIL stall_in_ready_c%0d got %b want 0", j, sv_rdy[j]); end
            checks++;
            if (sv_p[j] !== want || sv_t[j] !== op_t[0]) begin
                errors++;
                $display("FAIL stall_hold_c%0d got %h tag %h want %h tag %h", j, sv_p[j], sv_t[j], want, op_t[0]);
            end
        end
        for (int i = 0; i < 10; i++) begin
            want = 16'(ref_mul(N, 32'(op_a[i]), 32'(op_b[i]), op_s[i]));
            checks++;
            if (res_p[i] !== want || res_t[i] !== op_t[i] || res_c[i] !== res_c[0] + i) begin
                errors++;
                $display("FAIL stall_drain_op%0d got %h tag %h cyc %0d want %h tag %h cyc %0d",
                         i, res_p[i], res_t[i], res_c[i], want, op_t[i], res_c[0] + i);
            end
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (mbus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_extra_c%0d got out_valid %b tag %h want 0", k, mbus.out_valid, mbus.out_tag); end
        end
    endtask

    task automatic test_mid_reset();
        mbus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            mbus.in_valid = 1'b1; mbus.a = 8'(i + 3); mbus.b = 8'h11;
            mbus.in_signed = 1'b0; mbus.in_tag = 4'hA + 4'(i);
            #1;
            checks++;
            if (mbus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_accept%0d in_ready got %b want 1", i, mbus.in_ready); end
        end
        step();
        mbus.in_valid = 1'b0;
        step();
        // The reset edge is the one on which the oldest operation would emerge.
        step();
        rst = 1'b1;
        #1;
        checks++;
        if (mbus.in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready got %b want 0", mbus.in_ready); end
        step();
        rst = 1'b0;
        checks++;
        if (mbus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b want 0", mbus.out_valid); end
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (mbus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_ghost_c%0d out_valid %b tag %h want no result", k, mbus.out_valid, mbus.out_tag);
            end
        end
        op_a[0] = 8'hFD; op_b[0] = 8'h07; op_s[0] = 1'b1; op_t[0] = 4'h5;
        run_ops(1, 0, 30);
        checks++;
        if (res_p[0] !== 16'hFFEB || res_t[0] !== 4'h5) begin
            errors++;
            $display("FAIL rstmid_after got %h tag %h want FFEB tag 5", res_p[0], res_t[0]);
        end
    endtask

    task automatic test_other_shapes();
        alt_go = 1'b1;
        for (int k = 0; k < ALT_BUDGET + 500; k++) begin
            if (alt_done[0] && alt_done[1] && alt_done[2]) break;
            @(posedge clk);
        end
        checks++;
        if (!(alt_done[0] && alt_done[1] && alt_done[2])) begin
            errors++;
            $display("FAIL shapes_done got %b%b%b want 111", alt_done[2], alt_done[1], alt_done[0]);
        end
    endtask

    // (N,K) = (8,1), (8,8), (16,4): random mixed-mode traffic with random backpressure.
    for (genvar g = 0; g < 3; g++) begin : g_alt
        localparam int NN = (g == 2) ? 16 : 8;
        localparam int KK = (g == 0) ? 1 : ((g == 1) ? 8 : 4);

        pipelined_multiplier_rs_if #(.N(NN), .TAG_W(TAG_W)) abus ();
        pipelined_multiplier_rs #(.N(NN), .K(KK), .TAG_W(TAG_W)) u_dut (.clk(clk), .rst(rst), .bus(abus));

        initial begin : run
            logic [2*NN-1:0]  exp_p [$];
            logic [TAG_W-1:0] exp_t [$];
            logic [2*NN-1:0]  want_p;
            logic [TAG_W-1:0] want_t;
            int accepted;
            int consumed;
            int cycles;
            abus.in_valid = 1'b0; abus.a = '0; abus.b = '0;
            abus.in_signed = 1'b0; abus.in_tag = '0; abus.out_ready = 1'b0;
            wait (alt_go);
            accepted = 0;
            consumed = 0;
            cycles = 0;
            while (consumed < ALT_OPS && cycles < ALT_BUDGET) begin
                @(posedge clk);
                #1;
                cycles++;
                abus.in_valid  = (accepted < ALT_OPS) && ($urandom_range(0, 3) != 0);
                abus.a         = NN'($urandom);
                abus.b         = NN'($urandom);
                abus.in_signed = 1'($urandom);
                abus.in_tag    = TAG_W'($urandom);
                abus.out_ready = ($urandom_range(0, 3) != 0);
                #1;
                if (abus.out_valid && abus.out_ready) begin
                    checks++;
                    if (exp_p.size() == 0) begin
                        errors++;
                        $display("FAIL shape%0d_spurious got %h tag %h want no result", g, abus.product, abus.out_tag);
                    end else begin
                        want_p = exp_p.pop_front();
                        want_t = exp_t.pop_front();
                        if (abus.product !== want_p || abus.out_tag !== want_t) begin
                            errors++;
                            $display("FAIL shape%0d_op%0d got %h tag %h want %h tag %h",
                                     g, consumed, abus.product, abus.out_tag, want_p, want_t);
                        end
                    end
                    consumed++;
                end
                if (abus.in_valid && abus.in_ready) begin
                    exp_p.push_back((2 * NN)'(ref_mul(NN, 32'(abus.a), 32'(abus.b), abus.in_signed)));
                    exp_t.push_back(abus.in_tag);
                    accepted++;
                end
            end
            abus.in_valid = 1'b0;
            checks++;
            if (consumed != ALT_OPS) begin
                errors++;
                $display("FAIL shape%0d_count got %0d results want %0d", g, consumed, ALT_OPS);
            end
            alt_done[g] = 1'b1;
        end
    end

    initial begin
        mbus.in_valid = 1'b0; mbus.a = '0; mbus.b = '0;
        mbus.in_signed = 1'b0; mbus.in_tag = '0; mbus.out_ready = 1'b0;
        test_reset();
        test_latency();
        test_signed_modes();
        test_back_to_back();
        test_stall();
        test_mid_reset();
        test_other_shapes();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
